peak_position_tracker: RTL and testbench
========================================

# peak_position_tracker

Parametrised peak-hold tracker for the solar tracker's scan sequencer. It watches a windowed stream of ADC samples, each tagged with the servo pulse widths that produced it. Over each scan window it keeps the highest sample, with a hysteresis margin, plus the matching per-axis positions and sample index. At window close it commits these to stable outputs for the servo controller. It generalises the two-axis max register to N axes, configurable widths, explicit scan framing and a result handshake.

## Interface
- DATA_W, 12, sample width (ADC code)
- POS_W, 32, per-axis pulse-width width
- N_AXES, 2, number of servo axes
- HYST, 0, minimum margin (in sample LSBs) by which a sample must exceed the working max to replace it
- POS_RESET, 500, reset/default pulse width per axis
- IDX_W, 16, sample index/counter width

- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- scan_start  in  1  pulse; opens a new scan window
- scan_end  in  1  pulse; closes the current window
- sample_valid  in  1  qualifies sample/pos this cycle
- sample  in  DATA_W  ADC code
- pos  in  N_AXES*POS_W  current pulse widths; axis 0 in LSBs
- best_value  out  DATA_W  committed peak sample
- best_pos  out  N_AXES*POS_W  committed positions at peak
- best_index  out  IDX_W  index of peak sample within window
- best_found  out  1  committed window contained ≥1 sample
- result_valid  out  1  one-cycle pulse when the committed outputs change
- new_max  out  1  one-cycle pulse, cycle after a sample is accepted as the new working max
- busy  out  1  high in SCAN and COMMIT

## Operation
- States: IDLE, SCAN, COMMIT.
- IDLE: committed outputs hold.
  - scan_start → SCAN.
  - Working max cleared to 0, working pos to POS_RESET on all axes, working index 0, sample counter 0, found flag 0.
  - scan_end and sample_valid are ignored.
- SCAN, on each sample_valid:
  - counter increments, saturating at all-ones.
  - The sample is accepted if found==0, or if sample ≥ work_max + HYST + 1.
  - Comparison is done in DATA_W+2 bits, so a threshold above the maximum code never matches; no wrap.
  - On accept: work_max ← sample, work_pos ← pos, work_idx ← counter (pre-increment value), found ← 1, new_max pulses.
  - Ties and in-margin samples are rejected, so the earliest peak wins.
- SCAN, scan_start: restarts the window (working registers cleared as above). It takes priority over scan_end and sample_valid in the same cycle.
- SCAN, scan_end → COMMIT. A sample_valid in the same cycle is evaluated first and is included.
- COMMIT, single cycle: best_* ← working registers, best_found ← found, result_valid pulses, → IDLE. scan_start and samples arriving in COMMIT are ignored.
- Empty window: commits best_value=0, best_pos=POS_RESET, best_index=0, best_found=0; result_valid still pulses.
- RST, any time including mid-scan:
  - state IDLE
  - best_value 0, best_pos all POS_RESET, best_index 0, best_found 0
  - result_valid, new_max, busy 0
  - working registers cleared to the same values

## Timing
- All outputs registered.
- new_max: high in cycle k+1 for an accepted sample at edge k.
- Commit latency: scan_end at edge k → COMMIT in cycle k+1 → best_* and result_valid visible in cycle k+2.
- busy: rises in the cycle after the scan_start edge; falls together with the result_valid assertion.
- Back-to-back windows: scan_start is accepted earliest in the result_valid cycle, since the block is then IDLE.

## Structure
- Shared package tracker_pkg:
  - state enum (IDLE/SCAN/COMMIT)
  - default POS_RESET
  - axis-slice helper constant POS_W
- One sub-module, peak_compare: combinational sample vs. work_max+HYST with the found override. It is reused by the voltage comparator path.

## Test plan
- Reset mid-scan after 3 samples → all outputs at reset values next cycle; busy 0.
- Default params, window with samples 100, 300, 300, 200, pos 600/700/800/900 per step → best_value 300, best_index 1, best_pos 700 on both axes, new_max pulses twice.
- HYST=5: samples 100, 104, 106 → best_value 106, index 2; 104 rejected.
- scan_end with sample_valid in the same cycle carrying 4095 → best_value 4095; result_valid two cycles later.
- Empty window (start, end, no samples) → best_found 0, best_pos POS_RESET, result_valid pulse.
- scan_start mid-window after a peak of 900, then sample 50 → best_value 50 (window restarted).

Source files
------------

// File: rtl/tracker_pkg.sv
// Shared definitions for the scan peak tracker.
//   state_t        : scan sequencer states (IDLE / SCAN / COMMIT)
//   DEF_POS_W      : default per-axis pulse-width field width (axis slice size)
//   DEF_POS_RESET  : default pulse width loaded on reset / window open
package tracker_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam int unsigned DEF_POS_W     = 32;
   localparam int unsigned DEF_POS_RESET = 500;

endpackage : tracker_pkg

// File: rtl/peak_position_tracker_compare.sv
// peak_compare: combinational acceptance test of a sample against the
// working maximum plus a hysteresis margin.
//   sample_i   : candidate sample
//   work_max_i : current working maximum
//   found_i    : working maximum is valid (0 forces acceptance)
//   accept_o   : sample becomes the new working maximum
module peak_compare #(
   parameter int unsigned DATA_W = 12,
   parameter int unsigned HYST   = 0
) (
   input  logic [DATA_W-1:0] sample_i,
   input  logic [DATA_W-1:0] work_max_i,
   input  logic              found_i,
   output logic              accept_o
);

   localparam int unsigned CW = DATA_W + 2;

   logic [CW-1:0] thr;

   // Two guard bits keep work_max+HYST+1 from wrapping; a threshold above the
   // largest code simply never matches.
   assign thr      = {2'b00, work_max_i} + CW'(HYST) + CW'(1);
   assign accept_o = !found_i || ({2'b00, sample_i} >= thr);

endmodule : peak_compare

// File: rtl/peak_position_tracker.sv
// peak_position_tracker: per-window peak-hold of ADC samples with the servo
// positions and sample index that produced the peak.
//   CLK, RST          : clock, async active-high reset
//   scan_start        : open / restart a scan window
//   scan_end          : close the window (commit follows)
//   sample_valid      : qualifies sample / pos
//   sample, pos       : ADC code and N_AXES pulse widths (axis 0 in LSBs)
//   best_value/pos/index/found : committed window result
//   result_valid      : pulse when committed outputs update
//   new_max           : pulse the cycle after a new working max is taken
//   busy              : high while in SCAN or COMMIT
module peak_position_tracker
   import tracker_pkg::*;
#(
   parameter int unsigned DATA_W    = 12,
   parameter int unsigned POS_W     = DEF_POS_W,
   parameter int unsigned N_AXES    = 2,
   parameter int unsigned HYST      = 0,
   parameter int unsigned POS_RESET = DEF_POS_RESET,
   parameter int unsigned IDX_W     = 16
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    scan_start,
   input  logic                    scan_end,
   input  logic                    sample_valid,
   input  logic [DATA_W-1:0]       sample,
   input  logic [N_AXES*POS_W-1:0] pos,
   output logic [DATA_W-1:0]       best_value,
   output logic [N_AXES*POS_W-1:0] best_pos,
   output logic [IDX_W-1:0]        best_index,
   output logic                    best_found,
   output logic                    result_valid,
   output logic                    new_max,
   output logic                    busy
);

   localparam int unsigned PW = N_AXES * POS_W;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] work_max_q, work_max_d;
   logic [PW-1:0]     work_pos_q, work_pos_d;
   logic [IDX_W-1:0]  work_idx_q, work_idx_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              found_q, found_d;
   logic [DATA_W-1:0] best_value_q, best_value_d;
   logic [PW-1:0]     best_pos_q, best_pos_d;
   logic [IDX_W-1:0]  best_index_q, best_index_d;
   logic              best_found_q, best_found_d;
   logic              result_valid_q, result_valid_d;
   logic              new_max_q, new_max_d;
   logic              busy_q, busy_d;

   logic [PW-1:0]     pos_rst;
   logic              accept;

   for (genvar a = 0; a < N_AXES; a++) begin : g_pos_rst
      assign pos_rst[a*POS_W +: POS_W] = POS_W'(POS_RESET);
   end

   peak_compare #(
      .DATA_W (DATA_W),
      .HYST   (HYST)
   ) u_cmp (
      .sample_i   (sample),
      .work_max_i (work_max_q),
      .found_i    (found_q),
      .accept_o   (accept)
   );

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; scan_start in SCAN outranks scan_end
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (scan_start) state_d = SCAN;
         SCAN:    if (!scan_start && scan_end) state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      work_max_d     = work_max_q;
      work_pos_d     = work_pos_q;
      work_idx_d     = work_idx_q;
      cnt_d          = cnt_q;
      found_d        = found_q;
      best_value_d   = best_value_q;
      best_pos_d     = best_pos_q;
      best_index_d   = best_index_q;
      best_found_d   = best_found_q;
      result_valid_d = 1'b0;
      new_max_d      = 1'b0;
      busy_d         = (state_d != IDLE);
      unique case (state_q)
         IDLE: begin
            // Working set is held cleared so any scan_start opens a clean window
            work_max_d = '0;
            work_pos_d = pos_rst;
            work_idx_d = '0;
            cnt_d      = '0;
            found_d    = 1'b0;
         end
         SCAN: begin
            if (scan_start) begin
               work_max_d = '0;
               work_pos_d = pos_rst;
               work_idx_d = '0;
               cnt_d      = '0;
               found_d    = 1'b0;
            end else if (sample_valid) begin
               cnt_d = (&cnt_q) ? cnt_q : cnt_q + IDX_W'(1);
               if (accept) begin
                  work_max_d = sample;
                  work_pos_d = pos;
                  work_idx_d = cnt_q;
                  found_d    = 1'b1;
                  new_max_d  = 1'b1;
               end
            end
         end
         COMMIT: begin
            best_value_d   = work_max_q;
            best_pos_d     = work_pos_q;
            best_index_d   = work_idx_q;
            best_found_d   = found_q;
            result_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         work_max_q     <= '0;
         work_pos_q     <= pos_rst;
         work_idx_q     <= '0;
         cnt_q          <= '0;
         found_q        <= 1'b0;
         best_value_q   <= '0;
         best_pos_q     <= pos_rst;
         best_index_q   <= '0;
         best_found_q   <= 1'b0;
         result_valid_q <= 1'b0;
         new_max_q      <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         work_max_q     <= work_max_d;
         work_pos_q     <= work_pos_d;
         work_idx_q     <= work_idx_d;
         cnt_q          <= cnt_d;
         found_q        <= found_d;
         best_value_q   <= best_value_d;
         best_pos_q     <= best_pos_d;
         best_index_q   <= best_index_d;
         best_found_q   <= best_found_d;
         result_valid_q <= result_valid_d;
         new_max_q      <= new_max_d;
         busy_q         <= busy_d;
      end
   end

   assign best_value   = best_value_q;
   assign best_pos     = best_pos_q;
   assign best_index   = best_index_q;
   assign best_found   = best_found_q;
   assign result_valid = result_valid_q;
   assign new_max      = new_max_q;
   assign busy         = busy_q;

endmodule : peak_position_tracker

// File: tb/tb_peak_position_tracker.sv
module tb_peak_position_tracker;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        scan_start = 1'b0;
   logic        scan_end = 1'b0;
   logic        sample_valid = 1'b0;
   logic [11:0] sample = '0;
   logic [63:0] pos = '0;

   logic [11:0] bv0, bv5;
   logic [63:0] bp0, bp5;
   logic [15:0] bi0, bi5;
   logic        bf0, bf5, rv0, rv5, nm0, nm5, bz0, bz5;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   peak_position_tracker dut0 (
      .CLK(CLK), .RST(RST), .scan_start(scan_start), .scan_end(scan_end),
      .sample_valid(sample_valid), .sample(sample), .pos(pos),
      .best_value(bv0), .best_pos(bp0), .best_index(bi0), .best_found(bf0),
      .result_valid(rv0), .new_max(nm0), .busy(bz0)
   );

   peak_position_tracker #(.HYST(5)) dut5 (
      .CLK(CLK), .RST(RST), .scan_start(scan_start), .scan_end(scan_end),
      .sample_valid(sample_valid), .sample(sample), .pos(pos),
      .best_value(bv5), .best_pos(bp5), .best_index(bi5), .best_found(bf5),
      .result_valid(rv5), .new_max(nm5), .busy(bz5)
   );

   typedef struct {
      logic        st, en, v;
      logic [11:0] s;
      logic [31:0] p;
      logic        sel5;
      logic        rv, nm, bz;
      logic [11:0] bv;
      logic [15:0] bi;
      logic        bf;
      logic [31:0] bp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int st, input int en, input int v, input int s,
                               input int p, input int sel5, input int rv, input int nm,
                               input int bz, input int bv, input int bi, input int bf,
                               input int bp);
      vec_t r;
      r.st = st[0]; r.en = en[0]; r.v = v[0]; r.s = s[11:0]; r.p = p;
      r.sel5 = sel5[0]; r.rv = rv[0]; r.nm = nm[0]; r.bz = bz[0];
      r.bv = bv[11:0]; r.bi = bi[15:0]; r.bf = bf[0]; r.bp = bp;
      return r;
   endfunction

   task automatic chk(input string nm, input int row, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_bv0"}, -1, 64'(bv0), 64'd0);
      chk({tag, "_bp0"}, -1, bp0, {32'd500, 32'd500});
      chk({tag, "_bi0"}, -1, 64'(bi0), 64'd0);
      chk({tag, "_bf0"}, -1, 64'(bf0), 64'd0);
      chk({tag, "_rv0"}, -1, 64'(rv0), 64'd0);
      chk({tag, "_nm0"}, -1, 64'(nm0), 64'd0);
      chk({tag, "_bz0"}, -1, 64'(bz0), 64'd0);
      chk({tag, "_bv5"}, -1, 64'(bv5), 64'd0);
      chk({tag, "_bz5"}, -1, 64'(bz5), 64'd0);
   endtask

   initial begin
      // ---------------- vector table ----------------
      //        st en v  s     p    sel rv nm bz  bv    bi bf bp
      // default params: 100,300,300,200 ; tie rejected, earliest peak wins
      vecs.push_back(mk(1,0,0,   0,  0, 0, 0,0,1,    0, 0,0,500));
      vecs.push_back(mk(0,0,1, 100,600, 0, 0,1,1,    0, 0,0,500));
      vecs.push_back(mk(0,0,1, 300,700, 0, 0,1,1,    0, 0,0,500));
      vecs.push_back(mk(0,0,1, 300,800, 0, 0,0,1,    0, 0,0,500));
      vecs.push_back(mk(0,0,1, 200,900, 0, 0,0,1,    0, 0,0,500));
      vecs.push_back(mk(0,1,0,   0,  0, 0, 0,0,1,    0, 0,0,500));
      vecs.push_back(mk(0,0,0,   0,  0, 0, 1,0,0,  300, 1,1,700));
      // IDLE ignores scan_end / sample_valid
      vecs.push_back(mk(0,1,1, 999,  5, 0, 0,0,0,  300, 1,1,700));
      // HYST=5: 100, 104 (in margin), 106
      vecs.push_back(mk(1,0,0,   0,  0, 1, 0,0,1,  300, 1,1,700));
      vecs.push_back(mk(0,0,1, 100, 10, 1, 0,1,1,  300, 1,1,700));
      vecs.push_back(mk(0,0,1, 104, 20, 1, 0,0,1,  300, 1,1,700));
      vecs.push_back(mk(0,0,1, 106, 30, 1, 0,1,1,  300, 1,1,700));
      vecs.push_back(mk(0,1,0,   0,  0, 1, 0,0,1,  300, 1,1,700));
      vecs.push_back(mk(0,0,0,   0,  0, 1, 1,0,0,  106, 2,1, 30));
      // scan_end together with sample 4095; start/sample during COMMIT ignored
      vecs.push_back(mk(1,0,0,   0,  0, 0, 0,0,1,  106, 2,1, 30));
      vecs.push_back(mk(0,0,1,  10,  1, 0, 0,1,1,  106, 2,1, 30));
      vecs.push_back(mk(0,1,1,4095,  2, 0, 0,1,1,  106, 2,1, 30));
      vecs.push_back(mk(1,0,1,4000,  3, 0, 1,0,0, 4095, 1,1,  2));
      vecs.push_back(mk(0,0,0,   0,  0, 0, 0,0,0, 4095, 1,1,  2));
      // empty window
      vecs.push_back(mk(1,0,0,   0,  0, 0, 0,0,1, 4095, 1,1,  2));
      vecs.push_back(mk(0,1,0,   0,  0, 0, 0,0,1, 4095, 1,1,  2));
      vecs.push_back(mk(0,0,0,   0,  0, 0, 1,0,0,    0, 0,0,500));
      // restart mid-window after a peak of 900 (start beats the sample)
      vecs.push_back(mk(1,0,0,   0,  0, 0, 0,0,1,    0, 0,0,500));
      vecs.push_back(mk(0,0,1, 900,  7, 0, 0,1,1,    0, 0,0,500));
      vecs.push_back(mk(1,0,1,  50,  8, 0, 0,0,1,    0, 0,0,500));
      vecs.push_back(mk(0,0,1,  50,  9, 0, 0,1,1,    0, 0,0,500));
      vecs.push_back(mk(0,1,0,   0,  0, 0, 0,0,1,    0, 0,0,500));
      vecs.push_back(mk(0,0,0,   0,  0, 0, 1,0,0,   50, 0,1,  9));
      // HYST=5 near full scale: threshold 4098 never matches 4095
      vecs.push_back(mk(1,0,0,   0,  0, 1, 0,0,1,   50, 0,1,  9));
      vecs.push_back(mk(0,0,1,4092, 11, 1, 0,1,1,   50, 0,1,  9));
      vecs.push_back(mk(0,0,1,4095, 12, 1, 0,0,1,   50, 0,1,  9));
      vecs.push_back(mk(0,1,0,   0,  0, 1, 0,0,1,   50, 0,1,  9));
      vecs.push_back(mk(0,0,0,   0,  0, 1, 1,0,0, 4092, 0,1, 11));

      // ---------------- reset state ----------------
      repeat (2) @(negedge CLK);
      chk_reset("por");
      RST = 1'b0;

      // ---------------- table ----------------
      foreach (vecs[i]) begin
         logic [11:0] a_bv;
         logic [63:0] a_bp;
         logic [15:0] a_bi;
         logic        a_bf, a_rv, a_nm, a_bz;
         scan_start   = vecs[i].st;
         scan_end     = vecs[i].en;
         sample_valid = vecs[i].v;
         sample       = vecs[i].s;
         pos          = {vecs[i].p, vecs[i].p};
         @(posedge CLK);
         #1;
         if (vecs[i].sel5) begin
            a_bv = bv5; a_bp = bp5; a_bi = bi5; a_bf = bf5;
            a_rv = rv5; a_nm = nm5; a_bz = bz5;
         end else begin
            a_bv = bv0; a_bp = bp0; a_bi = bi0; a_bf = bf0;
            a_rv = rv0; a_nm = nm0; a_bz = bz0;
         end
         chk("result_valid", i, 64'(a_rv), 64'(vecs[i].rv));
         chk("new_max",      i, 64'(a_nm), 64'(vecs[i].nm));
         chk("busy",         i, 64'(a_bz), 64'(vecs[i].bz));
         chk("best_value",   i, 64'(a_bv), 64'(vecs[i].bv));
         chk("best_index",   i, 64'(a_bi), 64'(vecs[i].bi));
         chk("best_found",   i, 64'(a_bf), 64'(vecs[i].bf));
         chk("best_pos",     i, a_bp, {vecs[i].bp, vecs[i].bp});
         @(negedge CLK);
      end

      // ---------------- async reset mid-scan after 3 samples ----------------
      scan_start = 1'b1; scan_end = 1'b0; sample_valid = 1'b0;
      @(negedge CLK);
      scan_start = 1'b0; sample_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sample = 12'(1000 + k * 10);
         pos    = {32'(40 + k), 32'(40 + k)};
         @(negedge CLK);
      end
      sample_valid = 1'b0;
      chk("pre_rst_busy", -1, 64'(bz0), 64'd1);
      chk("pre_rst_new_max", -1, 64'(nm0), 64'd1);
      #2 RST = 1'b1;
      #1 chk_reset("async");
      @(negedge CLK);
      chk_reset("held");
      RST = 1'b0;

      // window after reset: working registers start clean
      scan_start = 1'b1;
      @(negedge CLK);
      scan_start = 1'b0; sample_valid = 1'b1; sample = 12'd5; pos = {32'd77, 32'd77};
      @(negedge CLK);
      sample_valid = 1'b0; scan_end = 1'b1;
      @(negedge CLK);
      scan_end = 1'b0;
      @(negedge CLK);
      chk("post_rst_rv", -1, 64'(rv0), 64'd1);
      chk("post_rst_bv", -1, 64'(bv0), 64'd5);
      chk("post_rst_bi", -1, 64'(bi0), 64'd0);
      chk("post_rst_bp", -1, bp0, {32'd77, 32'd77});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_peak_position_tracker
